sdram_trig_sched: RTL and testbench
===================================

Name: sdram_trig_sched

Overview:
Scheduler that sits between the write/read FIFOs and the SDRAM top-level controller and decides when to fire single-cycle wr_trig / rd_trig pulses.
- Writes are driven by write-FIFO fill level; reads by read-FIFO free space and by how many written bursts are still held in SDRAM.
- Round-robin between the two directions when both are eligible.
- Counts burst completion by watching FIFO handshake beats, and flags a stalled burst with a watchdog.

Parameters:
BURST_BEATS, 4, 8-bit FIFO beats transferred per trigger (one write or read burst)
FIFO_AW, 10, FIFO address width; level ports are FIFO_AW+1 bits, depth 2^FIFO_AW
MAX_BURSTS, 256, capacity of the SDRAM region in bursts; stored-burst counter saturates here
GAP_CYC, 2, idle cycles enforced after each burst before next trigger
TIMEOUT, 4095, max cycles without a beat while a burst is active

Ports:
sclk  input  1  system clock
s_rst_n  input  1  asynchronous active-low reset
enable  input  1  scheduler enable; 0 blocks new triggers, active burst still completes
wfifo_level  input  FIFO_AW+1  write-FIFO occupancy
rfifo_level  input  FIFO_AW+1  read-FIFO occupancy
wfifo_rd_en  input  1  write-FIFO pop strobe from SDRAM write path (beat monitor)
rfifo_wr_en  input  1  read-FIFO push strobe from SDRAM read path (beat monitor)
err_clr  input  1  clears timeout_err
wr_trig  output  1  one-cycle write trigger to SDRAM controller
rd_trig  output  1  one-cycle read trigger to SDRAM controller
busy  output  1  high in any state other than S_IDLE
stored_bursts  output  9  bursts written and not yet read back (0..MAX_BURSTS)
timeout_err  output  1  sticky watchdog flag

Behaviour:
- Reset (async, s_rst_n low):
  - state S_IDLE.
  - wr_trig, rd_trig, busy, timeout_err all 0.
  - stored_bursts 0; beat counter 0; gap counter 0; watchdog counter 0.
  - last_grant = READ, so the first tie goes to WRITE.
  - Reset mid-burst aborts the burst without updating stored_bursts.
- Eligibility is computed combinationally each cycle:
  - wr_elig = enable and wfifo_level >= BURST_BEATS and stored_bursts < MAX_BURSTS.
  - rd_elig = enable and stored_bursts > 0 and (2^FIFO_AW - rfifo_level) >= BURST_BEATS. The subtraction is done at FIFO_AW+1 bits, unsigned.
- State S_IDLE:
  - If only one direction is eligible, grant it.
  - If both are eligible, grant the one opposite last_grant.
  - On a grant: the matching trig is driven high for exactly the next cycle (registered), last_grant updates, and state goes to S_WR or S_RD.
  - If none is eligible, stay in S_IDLE.
- States S_WR / S_RD:
  - Count beats on wfifo_rd_en (S_WR) or rfifo_wr_en (S_RD). Beats from the other strobe are ignored.
  - Every beat resets the watchdog.
  - When beat_cnt reaches BURST_BEATS: in S_WR, stored_bursts increments; in S_RD, it decrements. Then go to S_GAP.
  - If the watchdog reaches TIMEOUT: set timeout_err, go to S_GAP, stored_bursts unchanged.
  - Extra beats beyond BURST_BEATS within the same burst are ignored.
- State S_GAP: hold GAP_CYC cycles, then go to S_IDLE. No trigger can be issued until S_IDLE is re-evaluated.
- Trigger spacing: at most one trig is high at any time, and it is never high outside the cycle after a grant.
- timeout_err is sticky until err_clr=1, which clears it the next cycle. If a new timeout occurs in the same cycle as err_clr, set wins.
- enable falling during S_WR/S_RD/S_GAP has no effect on the active sequence.
- Saturation: stored_bursts never exceeds MAX_BURSTS or goes below 0; eligibility guarantees this, and the counter is clamped as a backstop.

Test Plan:
1. After reset, enable=1, wfifo_level=4, rfifo_level=0 -> wr_trig high exactly 1 cycle. Then 4 wfifo_rd_en beats -> stored_bursts=1, busy drops 2 cycles after the last beat.
2. stored_bursts=1, wfifo_level=8, rfifo_level=0, last grant WRITE -> rd_trig issued first. After 4 rfifo_wr_en beats, stored_bursts=0; next grant is wr_trig.
3. rfifo_level=1021 (free 3), stored_bursts=3, wfifo_level=0 -> no rd_trig. Drop rfifo_level to 1020 -> rd_trig within 1 cycle.
4. Issue wr_trig, then supply no beats -> timeout_err=1 after 4095 cycles and stored_bursts unchanged. Pulse err_clr -> timeout_err=0.
5. Assert s_rst_n low after 2 of 4 beats -> all outputs 0 immediately. After release, stored_bursts=0 and no trig without eligibility.
6. stored_bursts=256, wfifo_level=1024 -> wr_trig never issued. Reads drain the count back to 255 -> wr_trig becomes eligible.

Source files
------------

// File: rtl/sdram_trig_sched.sv
// rtl/sdram_trig_sched.sv - fires single-cycle SDRAM write/read burst triggers
// from FIFO levels, tracks stored bursts and watches for stalled bursts.
module sdram_trig_sched #(
  parameter int BURST_BEATS = 4,
  parameter int FIFO_AW     = 10,
  parameter int MAX_BURSTS  = 256,
  parameter int GAP_CYC     = 2,
  parameter int TIMEOUT     = 4095
) (
  input  logic             sclk,
  input  logic             s_rst_n,
  input  logic             enable,
  input  logic [FIFO_AW:0] wfifo_level,
  input  logic [FIFO_AW:0] rfifo_level,
  input  logic             wfifo_rd_en,
  input  logic             rfifo_wr_en,
  input  logic             err_clr,
  output logic             wr_trig,
  output logic             rd_trig,
  output logic             busy,
  output logic [8:0]       stored_bursts,
  output logic             timeout_err
);

  localparam int LW = FIFO_AW + 1;
  localparam logic [LW-1:0] BEATS_LVL = LW'(BURST_BEATS);
  localparam logic [LW-1:0] DEPTH     = LW'(2 ** FIFO_AW);
  localparam logic [7:0]    BEATS_L   = 8'(BURST_BEATS);
  localparam logic [8:0]    MAX_L     = 9'(MAX_BURSTS);
  localparam logic [15:0]   GAP_L     = 16'(GAP_CYC);
  localparam logic [15:0]   TO_L      = 16'(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_WR, S_RD, S_GAP} state_t;

  localparam state_t S_DONE = (GAP_CYC == 0) ? S_IDLE : S_GAP;

  state_t      state_q, state_d;
  logic        wr_trig_q, wr_trig_d;
  logic        rd_trig_q, rd_trig_d;
  logic [8:0]  stored_q, stored_d;
  logic [7:0]  beat_q, beat_d;
  logic [15:0] wdog_q, wdog_d;
  logic [15:0] gap_q, gap_d;
  logic        last_wr_q, last_wr_d;
  logic        terr_q, terr_d;

  logic [LW-1:0] free_lvl;
  logic          wr_elig;
  logic          rd_elig;
  logic          beat_seen;
  logic          to_hit;

  always_comb begin
    free_lvl  = DEPTH - rfifo_level;
    wr_elig   = enable && (wfifo_level >= BEATS_LVL) && (stored_q < MAX_L);
    rd_elig   = enable && (stored_q != 9'd0) && (free_lvl >= BEATS_LVL);
    state_d   = state_q;
    wr_trig_d = 1'b0;
    rd_trig_d = 1'b0;
    stored_d  = stored_q;
    beat_d    = beat_q;
    wdog_d    = wdog_q;
    gap_d     = gap_q;
    last_wr_d = last_wr_q;
    beat_seen = 1'b0;
    to_hit    = 1'b0;

    case (state_q)
      S_IDLE: begin
        // On a tie the direction not served last time wins.
        if (wr_elig && (!rd_elig || !last_wr_q)) begin
          wr_trig_d = 1'b1;
          last_wr_d = 1'b1;
          state_d   = S_WR;
          beat_d    = 8'd0;
          wdog_d    = 16'd0;
        end else if (rd_elig) begin
          rd_trig_d = 1'b1;
          last_wr_d = 1'b0;
          state_d   = S_RD;
          beat_d    = 8'd0;
          wdog_d    = 16'd0;
        end
      end
      S_WR, S_RD: begin
        beat_seen = (state_q == S_WR) ? wfifo_rd_en : rfifo_wr_en;
        if (beat_seen) begin
          wdog_d = 16'd0;
          beat_d = beat_q + 8'd1;
          if (beat_q + 8'd1 == BEATS_L) begin
            state_d = S_DONE;
            beat_d  = 8'd0;
            gap_d   = 16'd0;
            if (state_q == S_WR)
              stored_d = (stored_q >= MAX_L) ? MAX_L : stored_q + 9'd1;
            else
              stored_d = (stored_q == 9'd0) ? 9'd0 : stored_q - 9'd1;
          end
        end else if (wdog_q + 16'd1 >= TO_L) begin
          to_hit  = 1'b1;
          state_d = S_DONE;
          beat_d  = 8'd0;
          wdog_d  = 16'd0;
          gap_d   = 16'd0;
        end else begin
          wdog_d = wdog_q + 16'd1;
        end
      end
      S_GAP: begin
        if (gap_q + 16'd1 >= GAP_L) begin
          state_d = S_IDLE;
          gap_d   = 16'd0;
        end else begin
          gap_d = gap_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A timeout in the same cycle as err_clr keeps the flag set.
    terr_d = to_hit | (terr_q & ~err_clr);
  end

  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      state_q   <= S_IDLE;
      wr_trig_q <= 1'b0;
      rd_trig_q <= 1'b0;
      stored_q  <= 9'd0;
      beat_q    <= 8'd0;
      wdog_q    <= 16'd0;
      gap_q     <= 16'd0;
      last_wr_q <= 1'b0;
      terr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_trig_q <= wr_trig_d;
      rd_trig_q <= rd_trig_d;
      stored_q  <= stored_d;
      beat_q    <= beat_d;
      wdog_q    <= wdog_d;
      gap_q     <= gap_d;
      last_wr_q <= last_wr_d;
      terr_q    <= terr_d;
    end
  end

  assign wr_trig       = wr_trig_q;
  assign rd_trig       = rd_trig_q;
  assign busy          = (state_q != S_IDLE);
  assign stored_bursts = stored_q;
  assign timeout_err   = terr_q;

endmodule

// File: tb/tb_sdram_trig_sched.sv
// tb/tb_sdram_trig_sched.sv - directed bench for sdram_trig_sched with a
// burst-level reference model compared every cycle.
module tb_sdram_trig_sched;

  logic        sclk;
  logic        s_rst_n;
  logic        enable;
  logic [10:0] wfifo_level;
  logic [10:0] rfifo_level;
  logic        wfifo_rd_en;
  logic        rfifo_wr_en;
  logic        err_clr;
  logic        wr_trig;
  logic        rd_trig;
  logic        busy;
  logic [8:0]  stored_bursts;
  logic        timeout_err;

  int vectors = 0;
  int errors  = 0;

  sdram_trig_sched dut (
    .sclk          (sclk),
    .s_rst_n       (s_rst_n),
    .enable        (enable),
    .wfifo_level   (wfifo_level),
    .rfifo_level   (rfifo_level),
    .wfifo_rd_en   (wfifo_rd_en),
    .rfifo_wr_en   (rfifo_wr_en),
    .err_clr       (err_clr),
    .wr_trig       (wr_trig),
    .rd_trig       (rd_trig),
    .busy          (busy),
    .stored_bursts (stored_bursts),
    .timeout_err   (timeout_err)
  );

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  // Reference model: a burst is either absent (0), a write (1) or a read (2);
  // after it ends, gap_left counts down the quiet cycles before a new grant.
  int m_burst, m_beats, m_quiet, m_gap_left, m_stored, m_free;
  bit m_last_wr, m_wr, m_rd, m_terr, m_wok, m_rok, m_hit, m_strobe;

  always @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      m_burst = 0; m_beats = 0; m_quiet = 0; m_gap_left = 0; m_stored = 0;
      m_last_wr = 0; m_wr = 0; m_rd = 0; m_terr = 0;
    end else begin
      m_free = (1024 - int'(rfifo_level) + 2048) % 2048;
      m_wok  = enable && (int'(wfifo_level) >= 4) && (m_stored < 256);
      m_rok  = enable && (m_stored > 0) && (m_free >= 4);
      m_hit  = 0;
      m_wr   = 0;
      m_rd   = 0;
      if (m_burst != 0) begin
        m_strobe = (m_burst == 1) ? wfifo_rd_en : rfifo_wr_en;
        if (m_strobe) begin
          m_beats++;
          m_quiet = 0;
          if (m_beats == 4) begin
            if (m_burst == 1) m_stored++; else m_stored--;
            m_burst = 0;
            m_gap_left = 2;
          end
        end else begin
          m_quiet++;
          if (m_quiet == 4095) begin
            m_hit = 1;
            m_burst = 0;
            m_gap_left = 2;
          end
        end
      end else if (m_gap_left > 0) begin
        m_gap_left--;
      end else if (m_wok && (!m_rok || !m_last_wr)) begin
        m_wr = 1; m_burst = 1; m_last_wr = 1; m_beats = 0; m_quiet = 0;
      end else if (m_rok) begin
        m_rd = 1; m_burst = 2; m_last_wr = 0; m_beats = 0; m_quiet = 0;
      end
      m_terr = m_hit || (m_terr && !err_clr);
    end
  end

  always @(negedge sclk) begin
    vectors++;
    if (wr_trig !== m_wr || rd_trig !== m_rd || busy !== ((m_burst != 0) || (m_gap_left > 0))
        || int'(stored_bursts) != m_stored || timeout_err !== m_terr) begin
      errors++;
      $display("FAIL cycle_cmp t=%0t got wr=%b rd=%b busy=%b stored=%0d terr=%b want wr=%b rd=%b busy=%b stored=%0d terr=%b",
               $time, wr_trig, rd_trig, busy, stored_bursts, timeout_err,
               m_wr, m_rd, (m_burst != 0) || (m_gap_left > 0), m_stored, m_terr);
    end
  end

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic beats(input bit wr, input int n, input bit other);
    for (int i = 0; i < n; i++) begin
      if (wr) begin wfifo_rd_en = 1'b1; rfifo_wr_en = other; end
      else    begin rfifo_wr_en = 1'b1; wfifo_rd_en = other; end
      @(negedge sclk);
    end
    wfifo_rd_en = 1'b0;
    rfifo_wr_en = 1'b0;
  endtask

  task automatic wait_trig(input bit wr, input string name);
    int n;
    n = 0;
    while (!(wr ? wr_trig : rd_trig) && n < 50) begin
      @(negedge sclk);
      n++;
    end
    check(name, int'(wr ? wr_trig : rd_trig), 1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 50) begin
      @(negedge sclk);
      n++;
    end
    check("wait_idle", int'(busy), 0);
  endtask

  initial begin
    int n;
    s_rst_n = 1'b0; enable = 1'b0; wfifo_level = '0; rfifo_level = '0;
    wfifo_rd_en = 1'b0; rfifo_wr_en = 1'b0; err_clr = 1'b0;
    repeat (3) @(negedge sclk);
    check("rst_busy", int'(busy), 0);
    check("rst_stored", int'(stored_bursts), 0);
    check("rst_trig", int'({wr_trig, rd_trig}), 0);
    s_rst_n = 1'b1;

    // 1: single write burst, then busy stays up for the two gap cycles.
    enable = 1'b1; wfifo_level = 11'd4; rfifo_level = 11'd0;
    @(negedge sclk);
    check("t1_wr_trig", int'(wr_trig), 1);
    check("t1_busy", int'(busy), 1);
    wfifo_level = 11'd0;
    @(negedge sclk);
    check("t1_wr_trig_one_cycle", int'(wr_trig), 0);
    beats(1'b1, 4, 1'b0);
    check("t1_stored", int'(stored_bursts), 1);
    check("t1_busy_gap0", int'(busy), 1);
    @(negedge sclk);
    check("t1_busy_gap1", int'(busy), 1);
    @(negedge sclk);
    check("t1_busy_drop", int'(busy), 0);

    // 2: both eligible after a write -> read first, then write.
    wfifo_level = 11'd8; rfifo_level = 11'd0;
    @(negedge sclk);
    check("t2_rd_first", int'(rd_trig), 1);
    check("t2_no_wr", int'(wr_trig), 0);
    beats(1'b0, 4, 1'b1);
    check("t2_stored", int'(stored_bursts), 0);
    n = 0;
    while (!wr_trig && n < 20) begin @(negedge sclk); n++; end
    check("t2_wr_latency", n, 3);
    wfifo_level = 11'd0;
    beats(1'b1, 4, 1'b0);
    wait_idle();

    // 3: read needs 4 free entries; an extra beat after completion is ignored.
    rfifo_level = 11'd1024; wfifo_level = 11'd4;
    wait_trig(1'b1, "t3_wr_a");
    beats(1'b1, 5, 1'b0);
    wait_trig(1'b1, "t3_wr_b");
    wfifo_level = 11'd0;
    beats(1'b1, 4, 1'b0);
    wait_idle();
    check("t3_stored3", int'(stored_bursts), 3);
    rfifo_level = 11'd1021;
    n = 0;
    for (int i = 0; i < 8; i++) begin @(negedge sclk); n += int'(rd_trig); end
    check("t3_no_rd_free3", n, 0);
    rfifo_level = 11'd1020;
    @(negedge sclk);
    check("t3_rd_free4", int'(rd_trig), 1);
    rfifo_level = 11'd1024;
    beats(1'b0, 4, 1'b0);
    check("t3_stored2", int'(stored_bursts), 2);
    wait_idle();

    // 4: stalled write burst trips the watchdog.
    wfifo_level = 11'd4;
    wait_trig(1'b1, "t4_wr");
    wfifo_level = 11'd0;
    n = 0;
    while (!timeout_err && n < 5000) begin @(negedge sclk); n++; end
    check("t4_timeout_cycles", n, 4095);
    check("t4_stored_kept", int'(stored_bursts), 2);
    wait_idle();
    check("t4_sticky", int'(timeout_err), 1);
    err_clr = 1'b1;
    @(negedge sclk);
    err_clr = 1'b0;
    check("t4_cleared", int'(timeout_err), 0);

    // 5: reset in the middle of a burst.
    wfifo_level = 11'd4;
    wait_trig(1'b1, "t5_wr");
    wfifo_level = 11'd0;
    beats(1'b1, 2, 1'b0);
    #2 s_rst_n = 1'b0;
    #1;
    check("t5_rst_busy", int'(busy), 0);
    check("t5_rst_stored", int'(stored_bursts), 0);
    check("t5_rst_trig", int'({wr_trig, rd_trig}), 0);
    @(negedge sclk);
    s_rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 10; i++) begin @(negedge sclk); n += int'(wr_trig) + int'(rd_trig); end
    check("t5_no_trig", n, 0);
    check("t5_idle", int'(busy), 0);

    // 6: fill to capacity, no write at 256, one read reopens writing.
    wfifo_level = 11'd1024; rfifo_level = 11'd1024;
    for (int i = 0; i < 256; i++) begin
      wait_trig(1'b1, "t6_fill_wr");
      beats(1'b1, 4, 1'b0);
    end
    check("t6_stored_full", int'(stored_bursts), 256);
    n = 0;
    for (int i = 0; i < 20; i++) begin @(negedge sclk); n += int'(wr_trig); end
    check("t6_no_wr_full", n, 0);
    rfifo_level = 11'd0;
    wait_trig(1'b0, "t6_rd");
    beats(1'b0, 4, 1'b0);
    check("t6_stored_255", int'(stored_bursts), 255);
    wait_trig(1'b1, "t6_wr_reopen");
    beats(1'b1, 4, 1'b0);
    check("t6_stored_refull", int'(stored_bursts), 256);
    enable = 1'b0;
    repeat (5) @(negedge sclk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
